// File: rtl/johnson_seq_ctrl_if.sv
// Command and status bundle for the Johnson-counter run controller.
// The master side issues run commands; the slave side owns the counter and reports status.
interface johnson_seq_ctrl_if #(
   parameter int N     = 4,
   parameter int CNT_W = 8
);
   localparam int PW = $clog2(2 * N);

   logic             start;
   logic             stop;
   logic             step;
   logic             load;
   logic [N-1:0]     load_val;
   logic [CNT_W-1:0] num_laps;
   logic [N-1:0]     Q;
   logic [PW-1:0]    phase_idx;
   logic [2*N-1:0]   phase_oh;
   logic [CNT_W-1:0] laps;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, stop, step, load, load_val, num_laps,
      input  Q, phase_idx, phase_oh, laps, busy, done, err
   );

   modport slave (
      input  start, stop, step, load, load_val, num_laps,
      output Q, phase_idx, phase_oh, laps, busy, done, err
   );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Run controller for an internal N-bit Johnson counter: lap-counted runs with pause,
// single-step, abort and preload, plus phase index / one-hot phase decode.
module johnson_seq_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input logic               CLK1,
   input logic               reset,
   johnson_seq_ctrl_if.slave bus
);
   localparam int PW = $clog2(2 * N);
   localparam logic [N-1:0] LAP_LAST = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0] laps_q, laps_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             adv_w;
   logic [CNT_W-1:0] laps_inc_w;
   logic [PW-1:0]    phase_idx_w;
   logic [2*N-1:0]   phase_oh_w;

   // A code is a legal Johnson state when adjacent bits differ at most once.
   function automatic logic is_johnson(input logic [N-1:0] q);
      int edges;
      edges = 0;
      for (int i = 0; i < N - 1; i++) begin
         if (q[i] != q[i+1]) begin
            edges = edges + 1;
         end else begin
            edges = edges + 0;
         end
      end
      return (edges <= 1);
   endfunction

   function automatic logic [PW-1:0] phase_of(input logic [N-1:0] q);
      int ones;
      ones = 0;
      for (int i = 0; i < N; i++) begin
         ones = ones + int'(q[i]);
      end
      if (q[N-1]) begin
         return PW'(2 * N - ones);
      end else begin
         return PW'(ones);
      end
   endfunction

   assign laps_inc_w = laps_q + CNT_W'(1'b1);

   // Command decode, counter advance and lap/completion bookkeeping.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      laps_d   = laps_q;
      target_d = target_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      adv_w    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               target_d = bus.num_laps;
               laps_d   = '0;
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end else if (bus.load) begin
               if (is_johnson(bus.load_val)) begin
                  cnt_d = bus.load_val;
               end else begin
                  cnt_d = '0;
                  err_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               state_d = ST_PAUSE;
            end else begin
               adv_w = 1'b1;
            end
         end
         ST_PAUSE: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               laps_d  = '0;
               busy_d  = 1'b0;
            end else if (bus.start) begin
               state_d = ST_RUN;
            end else if (bus.step) begin
               adv_w = 1'b1;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            laps_d  = '0;
            busy_d  = 1'b0;
         end
      endcase

      // Leaving the last state of a lap wraps Q to zero and closes the lap.
      if (adv_w) begin
         cnt_d = {cnt_q[N-2:0], ~cnt_q[N-1]};
         if (cnt_q == LAP_LAST) begin
            if ((target_q != '0) && (laps_inc_w == target_q)) begin
               laps_d  = target_q;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               laps_d = laps_inc_w;
            end
         end else begin
            laps_d = laps_q;
         end
      end else begin
         cnt_d = cnt_d;
      end
   end

   // State and status registers with synchronous reset.
   always_ff @(posedge CLK1) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         laps_q   <= '0;
         target_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         laps_q   <= laps_d;
         target_q <= target_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Phase decode straight from the counter register.
   always_comb begin
      phase_idx_w             = phase_of(cnt_q);
      phase_oh_w              = '0;
      phase_oh_w[phase_idx_w] = 1'b1;
   end

   assign bus.Q         = cnt_q;
   assign bus.phase_idx = phase_idx_w;
   assign bus.phase_oh  = phase_oh_w;
   assign bus.laps      = laps_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl (N=4, CNT_W=8): vector table plus
// hand-written pause/abort/load/free-run/reset sequences, checked through a scoreboard queue.
module tb_johnson_seq_ctrl;
   logic CLK1 = 1'b0;
   logic reset;

   always #5 CLK1 = ~CLK1;

   johnson_seq_ctrl_if #(.N(4), .CNT_W(8)) bus ();

   johnson_seq_ctrl #(.N(4), .CNT_W(8)) dut (
      .CLK1  (CLK1),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      nm;
      logic [3:0] q;
      logic [7:0] laps;
      logic       busy;
      logic       done;
      logic       err;
   } exp_t;

   typedef struct {
      logic       st, sp, stp, ld;
      logic [3:0] lv;
      logic [7:0] nl;
      logic [3:0] q;
      logic [7:0] laps;
      logic       busy, done, err;
   } vec_t;

   exp_t sb[$];
   vec_t vt[10];
   int   passed = 0;
   int   total  = 0;
   logic [3:0] seq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

   function automatic int idx_of(input logic [3:0] q);
      for (int i = 0; i < 8; i++) begin
         if (seq[i] == q) return i;
      end
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc(input logic r, input logic s, input logic sp, input logic stp,
                      input logic ld, input logic [3:0] lv, input logic [7:0] nl,
                      input logic [3:0] eq, input logic [7:0] el,
                      input logic eb, input logic ed, input logic ee, input string nm);
      exp_t e;
      exp_t g;
      logic [7:0] oh;
      reset        = r;
      bus.start    = s;
      bus.stop     = sp;
      bus.step     = stp;
      bus.load     = ld;
      bus.load_val = lv;
      bus.num_laps = nl;
      e.nm = nm; e.q = eq; e.laps = el; e.busy = eb; e.done = ed; e.err = ee;
      sb.push_back(e);
      @(posedge CLK1);
      #1;
      g  = sb.pop_front();
      oh = 8'h01 << idx_of(g.q);
      chk({g.nm, ".Q"},    32'(bus.Q),         32'(g.q));
      chk({g.nm, ".laps"}, 32'(bus.laps),      32'(g.laps));
      chk({g.nm, ".busy"}, 32'(bus.busy),      32'(g.busy));
      chk({g.nm, ".done"}, 32'(bus.done),      32'(g.done));
      chk({g.nm, ".err"},  32'(bus.err),       32'(g.err));
      chk({g.nm, ".pidx"}, 32'(bus.phase_idx), 32'(idx_of(g.q)));
      chk({g.nm, ".poh"},  32'(bus.phase_oh),  32'(oh));
   endtask

   initial begin
      // one-lap run, then a start in the done cycle that launches a 3-lap run
      vt[0] = '{1'b1,1'b0,1'b0,1'b0,4'h0,8'd1, 4'h0,8'd0,1'b1,1'b0,1'b0};
      vt[1] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h1,8'd0,1'b1,1'b0,1'b0};
      vt[2] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h3,8'd0,1'b1,1'b0,1'b0};
      vt[3] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h7,8'd0,1'b1,1'b0,1'b0};
      vt[4] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'hF,8'd0,1'b1,1'b0,1'b0};
      vt[5] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'hE,8'd0,1'b1,1'b0,1'b0};
      vt[6] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'hC,8'd0,1'b1,1'b0,1'b0};
      vt[7] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h8,8'd0,1'b1,1'b0,1'b0};
      vt[8] = '{1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd1,1'b0,1'b1,1'b0};
      vt[9] = '{1'b1,1'b0,1'b0,1'b0,4'h0,8'd3, 4'h0,8'd0,1'b1,1'b0,1'b0};

      cyc(1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b0,1'b0,1'b0,"rst0");
      cyc(1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b0,1'b0,1'b0,"rst1");

      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, vt[i].st, vt[i].sp, vt[i].stp, vt[i].ld, vt[i].lv, vt[i].nl,
             vt[i].q, vt[i].laps, vt[i].busy, vt[i].done, vt[i].err, $sformatf("vec%0d", i));
      end

      for (int k = 1; k <= 24; k++) begin
         cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, seq[k%8], 8'(k/8),
             (k < 24), (k == 24), 1'b0, $sformatf("lap3_%0d", k));
      end
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd3,1'b0,1'b0,1'b0,"lap3_end");

      // pause at 0111, hold, two steps, resume to completion
      cyc(1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,8'd1, 4'h0,8'd0,1'b1,1'b0,1'b0,"p_start");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h1,8'd0,1'b1,1'b0,1'b0,"p_a1");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h3,8'd0,1'b1,1'b0,1'b0,"p_a2");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h7,8'd0,1'b1,1'b0,1'b0,"p_a3");
      cyc(1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,8'd0, 4'h7,8'd0,1'b1,1'b0,1'b0,"p_stop");
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h7,8'd0,1'b1,1'b0,1'b0,"p_hold");
      end
      cyc(1'b0,1'b0,1'b0,1'b1,1'b0,4'h0,8'd0, 4'hF,8'd0,1'b1,1'b0,1'b0,"p_step1");
      cyc(1'b0,1'b0,1'b0,1'b1,1'b0,4'h0,8'd0, 4'hE,8'd0,1'b1,1'b0,1'b0,"p_step2");
      cyc(1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,8'd0, 4'hE,8'd0,1'b1,1'b0,1'b0,"p_resume");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'hC,8'd0,1'b1,1'b0,1'b0,"p_r1");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h8,8'd0,1'b1,1'b0,1'b0,"p_r2");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd1,1'b0,1'b1,1'b0,"p_done");

      // stop+start in RUN pauses; stop in PAUSE aborts
      cyc(1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,8'd2, 4'h0,8'd0,1'b1,1'b0,1'b0,"a_start");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h1,8'd0,1'b1,1'b0,1'b0,"a_a1");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h3,8'd0,1'b1,1'b0,1'b0,"a_a2");
      cyc(1'b0,1'b1,1'b1,1'b0,1'b0,4'h0,8'd0, 4'h3,8'd0,1'b1,1'b0,1'b0,"a_stopstart");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h3,8'd0,1'b1,1'b0,1'b0,"a_paused");
      cyc(1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b0,1'b0,1'b0,"a_abort");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b0,1'b0,1'b0,"a_idle");

      // preload legal/illegal, load ignored in RUN, early first lap from preload
      cyc(1'b0,1'b0,1'b0,1'b0,1'b1,4'h3,8'd0, 4'h3,8'd0,1'b0,1'b0,1'b0,"l_0011");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b1,4'h5,8'd0, 4'h0,8'd0,1'b0,1'b0,1'b1,"l_0101");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b0,1'b0,1'b0,"l_errclr");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b1,4'h3,8'd0, 4'h3,8'd0,1'b0,1'b0,1'b0,"l_reload");
      cyc(1'b0,1'b1,1'b0,1'b0,1'b1,4'h5,8'd1, 4'h3,8'd0,1'b1,1'b0,1'b0,"l_start");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b1,4'h5,8'd0, 4'h7,8'd0,1'b1,1'b0,1'b0,"l_r1");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b1,4'h5,8'd0, 4'hF,8'd0,1'b1,1'b0,1'b0,"l_r2");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b1,4'h5,8'd0, 4'hE,8'd0,1'b1,1'b0,1'b0,"l_r3");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b1,4'h5,8'd0, 4'hC,8'd0,1'b1,1'b0,1'b0,"l_r4");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b1,4'h5,8'd0, 4'h8,8'd0,1'b1,1'b0,1'b0,"l_r5");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd1,1'b0,1'b1,1'b0,"l_done");

      // free-run 40 cycles, pause, abort
      cyc(1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b1,1'b0,1'b0,"f_start");
      for (int k = 1; k <= 40; k++) begin
         cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, seq[k%8], 8'(k/8),
             1'b1, 1'b0, 1'b0, $sformatf("free_%0d", k));
      end
      cyc(1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd5,1'b1,1'b0,1'b0,"f_stop");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd5,1'b1,1'b0,1'b0,"f_paused");
      cyc(1'b0,1'b0,1'b1,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b0,1'b0,1'b0,"f_abort");

      // reset mid-run overrides all inputs
      cyc(1'b0,1'b1,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b1,1'b0,1'b0,"r_start");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h1,8'd0,1'b1,1'b0,1'b0,"r_a1");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h3,8'd0,1'b1,1'b0,1'b0,"r_a2");
      cyc(1'b1,1'b1,1'b0,1'b1,1'b1,4'h3,8'd5, 4'h0,8'd0,1'b0,1'b0,1'b0,"r_reset");
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,8'd0, 4'h0,8'd0,1'b0,1'b0,1'b0,"r_idle");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Run controller for an N-bit Johnson counter. The counter register is internal to this block.
- Sequences the counter through a programmed number of full laps (2N states each), with pause, single-step, abort and preload.
- Decodes the current state into a phase index and a one-hot phase-enable bus.
- Downstream datapath blocks use the phase bus to sequence their operations.

Parameters:
- N, 4, Johnson counter width; gives 2N states per lap.
- CNT_W, 8, width of the lap target and lap counter.

Ports:
- CLK1  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin run from IDLE, or resume from PAUSE.
- stop  input  1  RUN->PAUSE; in PAUSE, abort to IDLE.
- step  input  1  advance one state while in PAUSE.
- load  input  1  preload counter, honoured in IDLE only.
- load_val  input  N  preload value.
- num_laps  input  CNT_W  lap target, latched on start from IDLE; 0 = free-run.
- Q  output  N  Johnson counter state.
- phase_idx  output  $clog2(2N)  decoded state index, 0..2N-1.
- phase_oh  output  2N  one-hot of phase_idx.
- laps  output  CNT_W  completed laps in the current run.
- busy  output  1  high in RUN and PAUSE.
- done  output  1  one-cycle pulse when the target lap count completes.
- err  output  1  one-cycle pulse when load_val was illegal.

Behaviour:
- Single clock domain (CLK1); reset is synchronous and active-high. Everything is sampled on the rising CLK1 edge.
- Reset state: FSM=IDLE, Q=0, laps=0, target=0, busy=0, done=0, err=0. Hence phase_idx=0 and phase_oh=1.
- Advance rule: Q <= {Q[N-2:0], ~Q[N-1]}. For N=4 the sequence is 0000,0001,0011,0111,1111,1110,1100,1000, then back to 0000.
- Phase decode: combinational from Q.
  - If Q[N-1]=0, phase_idx = popcount(Q).
  - Otherwise, phase_idx = 2N - popcount(Q).
- Lap event: an advance out of state 1 followed by N-1 zeros (1000 for N=4) back to 0. On each lap event, laps <= laps+1, wrapping modulo 2^CNT_W.
- Command priority within one cycle: stop > start > step > load.
- IDLE state:
  - start: target<=num_laps, laps<=0, busy<=1, go to RUN. Q does not advance on this edge.
  - load: if load_val is a legal Johnson code, Q<=load_val. If illegal, Q<=0 and err=1 for one cycle.
  - stop and step are ignored.
- RUN state:
  - Q advances on every edge.
  - stop: go to PAUSE. Q holds on that edge (no advance).
  - start, load and num_laps changes are ignored.
- PAUSE state:
  - Q holds.
  - step: exactly one advance, then stay in PAUSE.
  - start: return to RUN; the target is not reloaded.
  - stop: abort. FSM=IDLE, Q<=0, laps<=0, busy<=0. No done pulse.
- Completion (applies in RUN and on a PAUSE step), when target != 0: on the edge where the lap event makes laps+1 == target, the block registers:
  - laps <= target
  - FSM <= IDLE
  - busy <= 0
  - done <= 1 for exactly one cycle
  - Q is 0 in that cycle.
- Free-run: with target=0 there is no completion. The block runs until stop, and laps wraps.
- Latency:
  - A K-lap run keeps busy high for 2N*K cycles.
  - done is asserted 2N*K cycles after the start edge, in the first cycle with busy=0.
  - A start sampled in the same cycle as the done pulse begins a new run.
- Preloaded Q: a run that starts from a nonzero Q completes its first lap early, at the first wrap to 0.
- Reset asserted mid-run overrides all inputs and returns every output to its reset value on the next edge.

Test Plan:
- Reset, then start with num_laps=1 (N=4) -> Q steps 0,1,3,7,F,E,C,8,0; phase_oh walks 01h..80h; busy high for 8 cycles; done pulses with Q=0, laps=1.
- num_laps=3 -> busy high for exactly 24 cycles; laps reads 1, 2, 3 at each wrap; single done pulse.
- Run with num_laps=1; stop at Q=0111 -> Q holds 3 cycles. Then step twice -> Q=1111, then 1110. Then start -> run resumes and done fires after 4 more cycles.
- In PAUSE, assert stop -> Q=0, busy=0, laps=0, no done. Assert stop and start together in RUN -> PAUSE entered (stop wins).
- In IDLE, load 0011 -> Q=0011, phase_idx=2, err=0. Load 0101 -> Q=0000, err pulses once. Assert load during RUN -> ignored.
- num_laps=0 free-run for 40 cycles, then stop -> laps=5, no done. Assert reset mid-run -> all outputs return to reset values on the next edge.
